// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n: N-approach, sensor-actuated traffic light controller.
// Approaches are served round-robin, and approaches with no request are skipped.
// Each green has a minimum time. It gaps out when its own demand drops and maxes out
// when another approach is waiting. An emergency input forces all-red.
// Optional pedestrian walk phase: define TLC_PED_WALK_EN.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR   = 4,
  parameter int TIMER_W   = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8,
  localparam int DIR_W    = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] req,
  input  logic               emerg,
`ifdef TLC_PED_WALK_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   phase_dir,
  output logic [1:0]         phase
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_T);
  localparam logic [TIMER_W-1:0] T_GMIN   = TIMER_W'(GREEN_MIN);
  localparam logic [TIMER_W-1:0] T_GMAX   = TIMER_W'(GREEN_MAX);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_T);
  localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK_T);

  state_t               state, state_nx;
  logic [DIR_W-1:0]     dir_nx, sel_dir;
  logic [TIMER_W-1:0]   timer;
  logic                 sel_hit, other, tmr_clr, ped_pend;
  logic [NUM_DIR-1:0]   dir_oh, oh_nx, green_nx, yellow_nx;
  int                   idx;

  assign phase = state;

`ifdef TLC_PED_WALK_EN
  logic ped_lat;
  assign ped_pend = ped_lat;

  // Pedestrian latch: a pulse sets it in any phase, and entering WALK consumes it.
  always_ff @(posedge clk) begin
    if (!rst_n)                                     ped_lat <= 1'b0;
    else if (state_nx == ST_WALK && state != ST_WALK) ped_lat <= 1'b0;
    else if (ped_req)                               ped_lat <= 1'b1;
  end

  // Walk lamp registered alongside the vehicle lamps.
  always_ff @(posedge clk) begin
    if (!rst_n) walk <= 1'b0;
    else        walk <= (state_nx == ST_WALK);
  end
`else
  assign ped_pend = 1'b0;
`endif

  // Next approach: nearest requester after phase_dir (with wrap); the current approach is checked last.
  always_comb begin
    sel_hit = 1'b0;
    sel_dir = phase_dir;
    idx     = 0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      idx = (int'(phase_dir) + k) % NUM_DIR;
      if (req[idx]) begin
        sel_hit = 1'b1;
        sel_dir = DIR_W'(idx);
      end
    end
  end

  // Next state, timer clear and next lamp pattern.
  always_comb begin
    state_nx = state;
    dir_nx   = phase_dir;
    tmr_clr  = 1'b0;
    dir_oh   = '0;
    dir_oh[phase_dir] = 1'b1;
    other    = (|(req & ~dir_oh)) | ped_pend;
    case (state)
      ST_ALLRED: begin
        // While emerg is held, the clearance keeps restarting, so a full clearance follows release.
        if (emerg) tmr_clr = 1'b1;
        else if (timer >= T_ALLRED) begin
          if (ped_pend) state_nx = ST_WALK;
          else if (sel_hit) begin
            state_nx = ST_GREEN;
            dir_nx   = sel_dir;
          end
        end
      end
      ST_GREEN:
        if (emerg || (other && timer >= T_GMIN && (!req[phase_dir] || timer >= T_GMAX)))
          state_nx = ST_YELLOW;
      ST_YELLOW:
        if (timer >= T_YELLOW) state_nx = ST_ALLRED;
      ST_WALK:
        if (emerg || timer >= T_WALK) state_nx = ST_ALLRED;
      default: state_nx = ST_ALLRED;
    endcase
    if (state_nx != state) tmr_clr = 1'b1;
    oh_nx = '0;
    oh_nx[dir_nx] = 1'b1;
    green_nx  = (state_nx == ST_GREEN)  ? oh_nx : '0;
    yellow_nx = (state_nx == ST_YELLOW) ? oh_nx : '0;
  end

  // State and served-approach registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ALLRED;
      phase_dir <= '0;
    end else begin
      state     <= state_nx;
      phase_dir <= dir_nx;
    end
  end

  // Phase timer: cleared on phase entry, counts ticks, saturates.
  always_ff @(posedge clk) begin
    if (!rst_n)                  timer <= '0;
    else if (tmr_clr)            timer <= '0;
    else if (tick && timer != '1) timer <= timer + 1'b1;
  end

  // Registered lamp drivers; red is the complement so exactly one lamp per approach is on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      green  <= '0;
      yellow <= '0;
      red    <= '1;
    end else begin
      green  <= green_nx;
      yellow <= yellow_nx;
      red    <= ~(green_nx | yellow_nx);
    end
  end

endmodule
